// File: rtl/dcache_assoc_sram_pkg.sv
// Shared widths and helpers for the set-associative data cache array.
// Defaults match the direct-mapped predecessor's address split.
package dcache_assoc_sram_pkg;

    localparam int TAG_W_DEF = 22;
    localparam int INDEX_W_DEF = 5;
    localparam int BLOCK_BYTES_DEF = 32;

    function automatic int blockBits(input int bytes);
        return 8 * bytes;
    endfunction

    // Way selects keep at least one bit even for a single-way cache
    function automatic int clog2Min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int plruBits(input int ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

endpackage

// File: rtl/dcache_assoc_sram_plru_tree.sv
// Tree pseudo-LRU for one set: next-state on an access and current victim.
// Node n (1-based heap order) lives in bit n-1; 0 steers the victim to the lower half.
module dcache_assoc_sram_plru_tree
    import dcache_assoc_sram_pkg::*;
#(
    parameter int WAYS = 2,
    localparam int WAY_W = clog2Min1(WAYS),
    localparam int PLRU_W = plruBits(WAYS)
) (
    input  logic [PLRU_W-1:0] plruIn,
    input  logic [WAY_W-1:0]  accWay,
    output logic [PLRU_W-1:0] plruOut,
    output logic [WAY_W-1:0]  victim
);

    if (WAYS == 1) begin : g_single
        assign plruOut = plruIn;
        assign victim = '0;
    end else begin : g_tree
        localparam int LV = WAY_W;

        logic [LV-1:0] match [WAYS];
        logic [WAYS-1:0] chosen;

        for (genvar n = 1; n < WAYS; n++) begin : g_node
            localparam int D = $clog2(n + 1) - 1;
            localparam int POS = n - (1 << D);
            logic onPath;
            if (D == 0) begin : g_root
                assign onPath = 1'b1;
            end else begin : g_inner
                assign onPath = (accWay[LV-1 -: D] == D'(POS));
            end
            // Point the node away from the way just touched
            assign plruOut[n-1] = onPath ? ~accWay[LV-1-D] : plruIn[n-1];
        end

        for (genvar w = 0; w < WAYS; w++) begin : g_way
            for (genvar d = 0; d < LV; d++) begin : g_lvl
                localparam int NODE = (WAYS + w) >> (LV - d);
                localparam logic DIR = 1'((w >> (LV - 1 - d)) & 1);
                assign match[w][d] = (plruIn[NODE-1] == DIR);
            end
            assign chosen[w] = &match[w];
        end

        always_comb begin
            victim = '0;
            for (int w = 0; w < WAYS; w++) begin
                if (chosen[w]) victim = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/dcache_assoc_sram.sv
// N-way set-associative data cache storage: tag match, byte writes,
// block fills, tree PLRU and victim presentation for write-back.
module dcache_assoc_sram
    import dcache_assoc_sram_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int TAG_W = TAG_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF,
    parameter int BLOCK_BYTES = BLOCK_BYTES_DEF,
    localparam int BLOCK_BITS = blockBits(BLOCK_BYTES),
    localparam int WAY_W = clog2Min1(WAYS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     wen,
    input  logic                     memWen,
    input  logic [BLOCK_BYTES-1:0]   bytesAccess,
    input  logic [TAG_W+INDEX_W-1:0] blockAddr,
    input  logic [BLOCK_BITS-1:0]    dataIn,
    output logic                     hit,
    output logic                     dirtyBit,
    output logic [BLOCK_BITS-1:0]    dataOut,
    output logic [TAG_W-1:0]         victimTag,
    output logic                     victimValid,
    output logic [WAY_W-1:0]         wayOut
);

    localparam int SETS = 1 << INDEX_W;
    localparam int PLRU_W = plruBits(WAYS);

    logic [TAG_W-1:0] tag;
    logic [INDEX_W-1:0] index;
    logic [WAYS-1:0] wayHit, wayValid, wayDirty, wayWrite;
    logic [TAG_W-1:0] wayTag [WAYS];
    logic [BLOCK_BITS-1:0] wayData [WAYS];
    logic [SETS-1:0][PLRU_W-1:0] plruMem;
    logic [PLRU_W-1:0] plruNext;
    logic [WAY_W-1:0] hitWay, invWay, plruVictim, victimWay, selWay;
    logic hitAny, doFill, doCpuWr, doTouch;
    logic [BLOCK_BITS-1:0] mergedData, writeData;

    assign {tag, index} = blockAddr;

    // Descending scan so the lowest matching/invalid way wins
    always_comb begin
        hitWay = '0;
        invWay = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (wayHit[w]) hitWay = WAY_W'(w);
            if (!wayValid[w]) invWay = WAY_W'(w);
        end
    end

    assign hitAny = |wayHit;
    assign victimWay = (&wayValid) ? plruVictim : invWay;
    assign selWay = hitAny ? hitWay : victimWay;
    assign doFill = rst & en & wen & memWen;
    assign doCpuWr = rst & en & wen & ~memWen & hitAny;
    assign doTouch = rst & en & (hitAny | doFill);

    always_comb begin
        mergedData = wayData[hitWay];
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (bytesAccess[i]) mergedData[8*i +: 8] = dataIn[8*i +: 8];
        end
    end

    assign writeData = memWen ? dataIn : mergedData;

    dcache_assoc_sram_plru_tree #(
        .WAYS(WAYS)
    ) uPlru (
        .plruIn (plruMem[index]),
        .accWay (selWay),
        .plruOut(plruNext),
        .victim (plruVictim)
    );

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [TAG_W-1:0] tagMem [SETS];
        logic [BLOCK_BITS-1:0] dataMem [SETS];
        logic [SETS-1:0] validMem, dirtyMem;

        assign wayValid[w] = validMem[index];
        assign wayDirty[w] = dirtyMem[index];
        assign wayTag[w] = tagMem[index];
        assign wayData[w] = dataMem[index];
        assign wayHit[w] = validMem[index] & (tagMem[index] == tag);
        assign wayWrite[w] = (doFill | doCpuWr) & (selWay == WAY_W'(w));

        always_ff @(posedge clk) begin
            if (wayWrite[w]) begin
                dataMem[index] <= writeData;
                if (memWen) tagMem[index] <= tag;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                validMem <= '0;
                dirtyMem <= '0;
            end else if (wayWrite[w]) begin
                validMem[index] <= 1'b1;
                dirtyMem[index] <= ~memWen;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            plruMem <= '0;
        end else if (doTouch) begin
            plruMem[index] <= plruNext;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit <= 1'b0;
            dirtyBit <= 1'b0;
            dataOut <= '0;
            victimTag <= '0;
            victimValid <= 1'b0;
            wayOut <= '0;
        end else if (en) begin
            hit <= hitAny | doFill;
            wayOut <= selWay;
            victimTag <= wayTag[victimWay];
            victimValid <= wayValid[victimWay];
            if (doFill) begin
                dataOut <= dataIn;
                dirtyBit <= 1'b0;
            end else if (doCpuWr) begin
                dataOut <= mergedData;
                dirtyBit <= 1'b1;
            end else begin
                dataOut <= wayData[selWay];
                dirtyBit <= wayDirty[selWay];
            end
        end
    end

endmodule

// File: tb/tb_dcache_assoc_sram.sv
// Directed bench for dcache_assoc_sram with a per-line behavioural model
// (LRU as most-recent way) checked on every cycle plus literal pins.
module tb_dcache_assoc_sram;

    logic clk = 1'b0;
    logic rst, en, wen, memWen;
    logic [31:0] bytesAccess;
    logic [26:0] blockAddr;
    logic [255:0] dataIn;
    logic hit, dirtyBit, victimValid;
    logic [255:0] dataOut;
    logic [21:0] victimTag;
    logic [0:0] wayOut;

    always #5 clk = ~clk;

    dcache_assoc_sram dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .wen(wen),
        .memWen(memWen),
        .bytesAccess(bytesAccess),
        .blockAddr(blockAddr),
        .dataIn(dataIn),
        .hit(hit),
        .dirtyBit(dirtyBit),
        .dataOut(dataOut),
        .victimTag(victimTag),
        .victimValid(victimValid),
        .wayOut(wayOut)
    );

    int passCnt = 0;
    int totalCnt = 0;
    bit checkOn = 1'b0;

    logic [21:0] mTag [32][2];
    bit mValid [32][2];
    bit mDirty [32][2];
    logic [255:0] mData [32][2];
    int mMru [32];

    bit eHit, eDirty, eVicValid, eZero;
    logic [255:0] eData;
    logic [21:0] eVicTag;
    int eWay;

    logic [255:0] ones;
    logic [255:0] dirtyBlk;
    logic [255:0] patA, patB;

    task automatic check(input string name, input logic [255:0] act,
                         input logic [255:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic model(input bit r, input bit e, input bit w, input bit m,
                         input logic [31:0] be, input logic [21:0] tg,
                         input int ix, input logic [255:0] d);
        int h, v, t;
        if (!r) begin
            for (int s = 0; s < 32; s++) begin
                for (int k = 0; k < 2; k++) begin
                    mValid[s][k] = 1'b0;
                    mDirty[s][k] = 1'b0;
                end
                mMru[s] = 1;
            end
            eHit = 0; eDirty = 0; eVicValid = 0; eZero = 1;
            eData = '0; eVicTag = '0; eWay = 0;
            return;
        end
        if (!e) return;
        eZero = 0;
        h = -1;
        for (int k = 0; k < 2; k++)
            if (mValid[ix][k] && mTag[ix][k] == tg) h = k;
        v = -1;
        for (int k = 1; k >= 0; k--)
            if (!mValid[ix][k]) v = k;
        if (v < 0) v = 1 - mMru[ix];
        eVicTag = mTag[ix][v];
        eVicValid = mValid[ix][v];
        if (w && m) begin
            t = (h >= 0) ? h : v;
            mData[ix][t] = d;
            mTag[ix][t] = tg;
            mValid[ix][t] = 1'b1;
            mDirty[ix][t] = 1'b0;
            mMru[ix] = t;
            eHit = 1; eData = d; eDirty = 0; eWay = t;
        end else if (h >= 0) begin
            if (w) begin
                for (int i = 0; i < 32; i++)
                    if (be[i]) mData[ix][h][8*i +: 8] = d[8*i +: 8];
                mDirty[ix][h] = 1'b1;
            end
            mMru[ix] = h;
            eHit = 1; eData = mData[ix][h]; eDirty = mDirty[ix][h]; eWay = h;
        end else begin
            eHit = 0; eData = mData[ix][v]; eDirty = mDirty[ix][v]; eWay = v;
        end
    endtask

    always @(negedge clk) begin
        if (checkOn) begin
            check("hit", hit, eHit);
            check("wayOut", wayOut, eWay);
            check("dirtyBit", dirtyBit, eDirty);
            if (eHit || eVicValid || eZero) check("dataOut", dataOut, eData);
            if (!eHit) begin
                check("victimValid", victimValid, eVicValid);
                if (eVicValid || eZero) check("victimTag", victimTag, eVicTag);
            end
        end
    end

    task automatic step(input bit r, input bit e, input bit w, input bit m,
                        input logic [31:0] be, input logic [21:0] tg,
                        input logic [4:0] ix, input logic [255:0] d);
        @(negedge clk);
        #1;
        rst = r; en = e; wen = w; memWen = m;
        bytesAccess = be; blockAddr = {tg, ix}; dataIn = d;
        model(r, e, w, m, be, tg, int'(ix), d);
    endtask

    task automatic rd(input logic [21:0] tg, input logic [4:0] ix);
        step(1, 1, 0, 0, 32'h0, tg, ix, '0);
    endtask

    task automatic fill(input logic [21:0] tg, input logic [4:0] ix,
                        input logic [255:0] d);
        step(1, 1, 1, 1, 32'h1234_5678, tg, ix, d);
    endtask

    task automatic wr(input logic [21:0] tg, input logic [4:0] ix,
                      input logic [31:0] be, input logic [255:0] d);
        step(1, 1, 1, 0, be, tg, ix, d);
    endtask

    task automatic settle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; en = 0; wen = 0; memWen = 0;
        bytesAccess = '0; blockAddr = '0; dataIn = '0;
        ones = '1;
        dirtyBlk = {8'hAA, ones[247:0]};
        patA = {8{32'hC0DE_0001}};
        patB = {8{32'h5A5A_0F0F}};

        step(0, 1, 1, 1, '1, 22'h5, 5'd0, ones);
        checkOn = 1'b1;
        step(0, 0, 0, 0, '0, 22'h0, 5'd0, '0);

        rd(22'h1, 5'd0); settle;
        check("rst_rd_hit", hit, 0);
        check("rst_rd_vvalid", victimValid, 0);
        check("rst_rd_way", wayOut, 0);
        check("rst_rd_dirty", dirtyBit, 0);

        fill(22'h1, 5'd0, '0);
        fill(22'h3FFFFF, 5'd0, ones); settle;
        check("fill2_way", wayOut, 1);
        rd(22'h1, 5'd0); settle;
        check("rd1_hit", hit, 1);
        check("rd1_data", dataOut, 0);
        rd(22'h3FFFFF, 5'd0); settle;
        check("rdF_data", dataOut, ones);
        check("rdF_dirty", dirtyBit, 0);

        wr(22'h3FFFFF, 5'd0, 32'h8000_0000, {8'hAA, {31{8'h55}}}); settle;
        check("wr_data", dataOut, dirtyBlk);
        check("wr_dirty", dirtyBit, 1);
        rd(22'h3FFFFF, 5'd0); settle;
        check("rdw_data", dataOut, dirtyBlk);
        check("rdw_hit", hit, 1);

        rd(22'h1, 5'd0);
        rd(22'h2, 5'd0); settle;
        check("miss_vtag", victimTag, 22'h3FFFFF);
        check("miss_vvalid", victimValid, 1);
        check("miss_dirty", dirtyBit, 1);
        check("miss_way", wayOut, 1);
        check("miss_data", dataOut, dirtyBlk);

        step(1, 0, 1, 1, '1, 22'h9, 5'd0, '0);
        step(1, 0, 0, 0, '1, 22'h1, 5'd0, ones);

        fill(22'h2, 5'd0, patA); settle;
        check("evict_way", wayOut, 1);
        rd(22'h3FFFFF, 5'd0); settle;
        check("evicted_miss", hit, 0);

        wr(22'h7, 5'd0, '1, ones); settle;
        check("wrmiss_hit", hit, 0);
        rd(22'h1, 5'd0); settle;
        check("after_wrmiss_1", dataOut, 0);
        rd(22'h2, 5'd0); settle;
        check("after_wrmiss_2", dataOut, patA);

        wr(22'h1, 5'd0, 32'h0, ones); settle;
        check("be0_data", dataOut, 0);
        check("be0_dirty", dirtyBit, 1);

        fill(22'hA, 5'd31, patB);
        rd(22'hA, 5'd31);
        rd(22'hB, 5'd31); settle;
        check("set31_vvalid", victimValid, 0);
        check("set31_way", wayOut, 1);
        fill(22'h3FFFFF, 5'd0, patB);
        rd(22'h1, 5'd0);
        rd(22'h2, 5'd0);

        step(0, 1, 1, 1, '1, 22'h3, 5'd0, ones); settle;
        check("rstfill_hit", hit, 0);
        check("rstfill_data", dataOut, 0);
        rd(22'h1, 5'd0); settle;
        check("postrst_1", hit, 0);
        rd(22'h2, 5'd0); settle;
        check("postrst_2", hit, 0);

        step(1, 0, 0, 0, '0, 22'h0, 5'd0, '0);
        @(negedge clk);
        #2;
        checkOn = 1'b0;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/dcache_assoc_sram.md
Name: dcache_assoc_sram

Overview:
Parametrised N-way set-associative data-cache storage array, successor to the direct-mapped data SRAM. Holds tag, valid, dirty and data per way, and does the tag compare across all ways. Applies byte-enable CPU writes and whole-block memory fills, and tracks tree pseudo-LRU per set. On a miss it presents the victim block, its tag and its dirty bit, so the cache controller FSM can write it back before filling.

Parameters:
WAYS, 2, associativity; power of 2, range 1..8
TAG_W, 22, tag bits
INDEX_W, 5, set index bits; sets = 2**INDEX_W
BLOCK_BYTES, 32, bytes per block; BLOCK_BITS = 8*BLOCK_BYTES

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous reset, active-low (rst=0 resets at the next rising edge)
en  in  1  access strobe; no state change and outputs hold when 0
wen  in  1  write request (qualified by en)
memWen  in  1  with wen=1: whole-block fill from memory; 0: CPU byte write
bytesAccess  in  BLOCK_BYTES  byte enables for CPU write; bit i covers data byte i
blockAddr  in  TAG_W+INDEX_W  {tag, index}
dataIn  in  BLOCK_BITS  write/fill data
hit  out  1  registered lookup result
dirtyBit  out  1  dirty bit of hit way (hit=1) or of victim way (hit=0)
dataOut  out  BLOCK_BITS  block of hit way, or victim block on miss
victimTag  out  TAG_W  tag of victim way (valid when hit=0)
victimValid  out  1  victim way holds a valid line (write-back candidate)
wayOut  out  log2(WAYS) (min 1)  way hit or way chosen as victim

Behaviour:
- Reset (rst=0 at an edge):
  - clears all valid bits, dirty bits and PLRU bits.
  - all outputs go to 0.
  - data and tag arrays are not cleared.
  - reset dominates any concurrent en/wen; an access issued in the reset cycle is dropped.
- Latency: every en=1 access samples its inputs at edge N. Outputs reflect that access after edge N and hold until the next en=1 edge. With en=0, outputs hold.
- Lookup: hit = OR over ways of (valid & tag==blockAddr tag). At most one way may match; a fill never creates a duplicate.
- Victim choice (on miss):
  - the lowest-index invalid way, if any;
  - otherwise the way given by the set's PLRU tree.
- Read (en=1, wen=0):
  - On hit: dataOut/dirtyBit are the hit way's; PLRU is updated to mark that way most recent.
  - On miss: dataOut, dirtyBit, victimTag and victimValid describe the victim way; no state changes.
- CPU write (en=1, wen=1, memWen=0):
  - On hit: for each i with bytesAccess[i]=1, byte i is replaced by dataIn byte i, and the way's dirty bit is set. If bytesAccess=0 the data is unchanged but dirty is still set. PLRU is updated. Outputs show the post-write block, with dirtyBit=1.
  - On miss: no array change. Outputs show the victim, as for a read miss.
- Fill (en=1, wen=1, memWen=1):
  - If the tag already hits, that way is overwritten; otherwise the victim way is written. bytesAccess is ignored.
  - Full block written, tag written, valid=1, dirty=0, PLRU updated.
  - Outputs: hit=1, dataOut=dataIn, dirtyBit=0, wayOut = written way.
- PLRU: WAYS-1 bits per set, standard binary tree; an access points every node on the path away from the accessed way. With WAYS=1 the PLRU has no bits and the victim is always way 0.
- Back-to-back accesses are allowed every cycle. A read to the same set in the cycle after a write sees the written data.

Decomposition:
- Shared constants header holds: default TAG/INDEX/BLOCK widths, the BLOCK_BITS derivation, and a clog2 helper macro/function.
- One sub-module, plru_tree:
  - combinational, parametrised by WAYS;
  - inputs: the set's current PLRU bits and the accessed way;
  - outputs: next PLRU bits and victim way.
- Tag/valid/dirty/data arrays stay in the top module, as a generate loop over ways.

Test Plan:
- Reset, then read tag 0x1, index 0 -> hit=0, victimValid=0, wayOut=0, dirtyBit=0.
- Fill index 0 with tag 0x1, dataIn all-0, then fill index 0 with tag 0x3FFFFF, dataIn all-1 -> second fill lands in way 1. Reading each tag then gives hit=1, the correct data, and dirtyBit=0.
- CPU write to tag 0x3FFFFF, index 0, with bytesAccess=1 in bit 31 only and dataIn byte 31=0xAA, then read -> byte 31=0xAA, other bytes 0xFF, dirtyBit=1, hit=1.
- PLRU eviction:
  - Read tag 0x1 (way 0 made most recent), then fill tag 0x2 at index 0 -> way 1 is the victim.
  - Before that fill, a read miss on tag 0x2 gives victimTag=0x3FFFFF, victimValid=1, dirtyBit=1, dataOut = the dirty block.
- CPU write miss on tag 0x7 -> hit=0, no array change; a subsequent read shows both resident lines unchanged.
- Apply rst=0 for one edge in the middle of a fill -> outputs are 0 the next cycle, and reads of previously filled tags miss.
